// File: rtl/tick_chain_if.sv
// Control/status bundle for tick_chain_gen.
// master = controller side (drives run/restart/divisors), slave = generator.
// When TICK_CHAIN_HEARTBEAT_EN is defined the bundle also carries hb_o.
interface tick_chain_if #(
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 12
);
  logic                        run;
  logic                        restart;
  logic [NUM_STAGES*CNT_W-1:0] div_val;
  logic                        div_upd;
  logic [NUM_STAGES-1:0]       upd_pend;
  logic [NUM_STAGES-1:0]       tick_o;
`ifdef TICK_CHAIN_HEARTBEAT_EN
  logic [NUM_STAGES-1:0]       hb_o;

  modport master (
    output run, restart, div_val, div_upd,
    input  upd_pend, tick_o, hb_o
  );
  modport slave (
    input  run, restart, div_val, div_upd,
    output upd_pend, tick_o, hb_o
  );
`else
  modport master (
    output run, restart, div_val, div_upd,
    input  upd_pend, tick_o
  );
  modport slave (
    input  run, restart, div_val, div_upd,
    output upd_pend, tick_o
  );
`endif
endinterface

// File: rtl/tick_chain_gen.sv
// tick_chain_gen: runtime-programmable cascaded tick-enable generator.
// Stage 0 counts run cycles, stage k counts stage k-1 wraps. Each stage
// emits a registered 1-clk tick at its terminal count. New divisors are
// staged and only reach a stage's active (shadow) divisor at that stage's
// wrap or on restart, so a period is never cut short or stretched.
// Optional feature macro: TICK_CHAIN_HEARTBEAT_EN (adds hb_o square waves).
module tick_chain_gen #(
  parameter int                          NUM_STAGES = 3,
  parameter int                          CNT_W      = 12,
  parameter logic [NUM_STAGES*CNT_W-1:0] DIV_INIT   = {12'd100, 12'd10, 12'd2}
) (
  input  logic         clk,
  input  logic         nrst,
  tick_chain_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]      cnt_q     [NUM_STAGES];
  logic [CNT_W-1:0]      cnt_d     [NUM_STAGES];
  logic [CNT_W-1:0]      shadow_q  [NUM_STAGES];
  logic [CNT_W-1:0]      shadow_d  [NUM_STAGES];
  logic [CNT_W-1:0]      staging_q [NUM_STAGES];
  logic [CNT_W-1:0]      staging_d [NUM_STAGES];
  logic [NUM_STAGES-1:0] pend_q;
  logic [NUM_STAGES-1:0] pend_d;
  logic [NUM_STAGES-1:0] tick_q;
  logic [NUM_STAGES-1:0] tick_d;
`ifdef TICK_CHAIN_HEARTBEAT_EN
  logic [NUM_STAGES-1:0] hb_q;
  logic [NUM_STAGES-1:0] hb_d;
`endif

  logic [NUM_STAGES-1:0] src_s;
  logic [NUM_STAGES-1:0] wrap_s;

  // Ripple the source event down the chain: a stage only sees an event when
  // the stage below wraps in the same cycle, so all stages may wrap together.
  always_comb begin
    logic             carry_s;
    logic [CNT_W-1:0] eff_div_s;
    carry_s = bus.run;
    src_s   = '0;
    wrap_s  = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      // A zero divisor behaves as divide-by-one.
      eff_div_s = (shadow_q[k] == CNT_ZERO) ? CNT_ONE : shadow_q[k];
      src_s[k]  = carry_s;
      wrap_s[k] = carry_s && (cnt_q[k] == (eff_div_s - CNT_ONE));
      carry_s   = wrap_s[k];
    end
  end

  // Next-state: restart wins over counting; a divisor update in the same
  // cycle as a wrap stays pending until that stage's following wrap.
  always_comb begin
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    staging_d = staging_q;
    pend_d    = pend_q;
    tick_d    = '0;
`ifdef TICK_CHAIN_HEARTBEAT_EN
    hb_d      = hb_q;
`endif
    if (bus.restart) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        cnt_d[k] = CNT_ZERO;
        if (bus.div_upd) begin
          shadow_d[k]  = bus.div_val[k*CNT_W +: CNT_W];
          staging_d[k] = bus.div_val[k*CNT_W +: CNT_W];
        end else if (pend_q[k]) begin
          shadow_d[k] = staging_q[k];
        end else begin
          shadow_d[k] = shadow_q[k];
        end
      end
      pend_d = '0;
      tick_d = '0;
`ifdef TICK_CHAIN_HEARTBEAT_EN
      hb_d   = '0;
`endif
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (wrap_s[k]) begin
          cnt_d[k] = CNT_ZERO;
        end else if (src_s[k]) begin
          cnt_d[k] = cnt_q[k] + CNT_ONE;
        end else begin
          cnt_d[k] = cnt_q[k];
        end

        if (bus.div_upd) begin
          staging_d[k] = bus.div_val[k*CNT_W +: CNT_W];
          pend_d[k]    = 1'b1;
          shadow_d[k]  = shadow_q[k];
        end else if (wrap_s[k] && pend_q[k]) begin
          shadow_d[k] = staging_q[k];
          pend_d[k]   = 1'b0;
        end else begin
          shadow_d[k] = shadow_q[k];
        end
      end
      tick_d = wrap_s;
`ifdef TICK_CHAIN_HEARTBEAT_EN
      hb_d   = hb_q ^ wrap_s;
`endif
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        cnt_q[k]     <= CNT_ZERO;
        shadow_q[k]  <= DIV_INIT[k*CNT_W +: CNT_W];
        staging_q[k] <= DIV_INIT[k*CNT_W +: CNT_W];
      end
      pend_q <= '0;
      tick_q <= '0;
`ifdef TICK_CHAIN_HEARTBEAT_EN
      hb_q   <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      staging_q <= staging_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
`ifdef TICK_CHAIN_HEARTBEAT_EN
      hb_q      <= hb_d;
`endif
    end
  end

  assign bus.upd_pend = pend_q;
  assign bus.tick_o   = tick_q;
`ifdef TICK_CHAIN_HEARTBEAT_EN
  assign bus.hb_o     = hb_q;
`endif

endmodule
